// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: lap snapshot word layout, recall FSM states, default depth.
package stopwatch_pkg;

  localparam int LAP_DEPTH_DEF = 8;

  // Snapshot layout {min, sec_tens, sec_ones, ms_tens, ms_ones}
  localparam int LAP_W        = 17;
  localparam int MS_ONES_LSB  = 0;
  localparam int MS_TENS_LSB  = 4;
  localparam int SEC_ONES_LSB = 8;
  localparam int SEC_TENS_LSB = 12;
  localparam int MIN_BIT      = 16;

  typedef logic [LAP_W-1:0] lap_word_t;

  typedef enum logic {
    ST_LIVE   = 1'b0,
    ST_RECALL = 1'b1
  } state_e;

  function automatic lap_word_t pack_lap(input logic min, input logic [3:0] sec_tens,
                                         input logic [3:0] sec_ones, input logic [3:0] ms_tens,
                                         input logic [3:0] ms_ones);
    return {min, sec_tens, sec_ones, ms_tens, ms_ones};
  endfunction

endpackage

// File: rtl/lap_buffer.sv
// Circular lap store: write/pointer/count bookkeeping and the full-buffer policy.
// LAP_OVERWRITE_EN: when defined, a capture into a full buffer replaces the oldest lap.
module lap_buffer
  import stopwatch_pkg::*;
#(
  parameter int LAP_DEPTH = LAP_DEPTH_DEF,
  localparam int PW = $clog2(LAP_DEPTH),
  localparam int CW = $clog2(LAP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          wr_en,
  input  lap_word_t     wr_data,
  input  logic [PW-1:0] rd_off,
  output lap_word_t     rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          reject
);

  lap_word_t     mem_q [LAP_DEPTH];
  lap_word_t     mem_d [LAP_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_base_q, rd_base_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          reject_q, reject_d;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_base_d = rd_base_q;
    count_d   = count_q;
    reject_d  = 1'b0;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_base_d = '0;
      count_d   = '0;
    end else if (wr_en) begin
      if (!full_q) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
        count_d         = count_q + CW'(1);
      end else begin
`ifdef LAP_OVERWRITE_EN
        // When full, wr_ptr sits on the oldest entry, so the base moves past it.
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
        rd_base_d       = rd_base_q + PW'(1);
`else
        reject_d = 1'b1;
`endif
      end
    end
    full_d = (count_d == CW'(LAP_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_base_q <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_base_q <= rd_base_d;
      count_q   <= count_d;
      full_q    <= full_d;
      reject_q  <= reject_d;
    end
  end

  // Pointer width wraps modulo LAP_DEPTH for free.
  assign rd_data = mem_q[rd_base_q + rd_off];
  assign count   = count_q;
  assign full    = full_q;
  assign reject  = reject_q;

endmodule

// File: rtl/lap_recall_ctrl.sv
// Lap capture and display-source scheduler: LIVE/RECALL FSM, selection and output registers.
// LAP_OVERWRITE_EN selects the full-buffer policy inside lap_buffer.
module lap_recall_ctrl
  import stopwatch_pkg::*;
#(
  parameter int LAP_DEPTH = LAP_DEPTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             lap_pulse,
  input  logic                             recall_pulse,
  input  logic                             clear_pulse,
  input  logic                             timer_running,
  input  logic [3:0]                       live_ms_tens,
  input  logic [3:0]                       live_ms_ones,
  input  logic [3:0]                       live_sec_tens,
  input  logic [3:0]                       live_sec_ones,
  input  logic                             live_min,
  output logic [3:0]                       disp_ms_tens,
  output logic [3:0]                       disp_ms_ones,
  output logic [3:0]                       disp_sec_tens,
  output logic [3:0]                       disp_sec_ones,
  output logic                             disp_min,
  output logic                             recall_mode,
  output logic [3:0]                       lap_index,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
  output logic                             buf_full,
  output logic                             lap_reject
);

  localparam int PW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  state_e        state_q, state_d;
  logic [PW-1:0] sel_q, sel_d;
  lap_word_t     disp_q, disp_d;
  logic          recall_mode_q, recall_mode_d;
  logic [3:0]    lap_index_q, lap_index_d;

  lap_word_t     live_word, rd_data;
  logic [CW-1:0] cnt;

  assign live_word = pack_lap(live_min, live_sec_tens, live_sec_ones, live_ms_tens, live_ms_ones);

  lap_buffer #(.LAP_DEPTH(LAP_DEPTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_pulse),
    .wr_en   (lap_pulse & timer_running),
    .wr_data (live_word),
    .rd_off  (sel_d),
    .rd_data (rd_data),
    .count   (cnt),
    .full    (buf_full),
    .reject  (lap_reject)
  );

  // cnt is the pre-capture count, so a same-cycle lap does not extend the recall walk.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (clear_pulse) begin
      state_d = ST_LIVE;
      sel_d   = '0;
    end else if (recall_pulse) begin
      if (state_q == ST_LIVE) begin
        if (cnt != '0) begin
          state_d = ST_RECALL;
          sel_d   = '0;
        end
      end else if (sel_q == PW'(cnt - CW'(1))) begin
        state_d = ST_LIVE;
        sel_d   = '0;
      end else begin
        sel_d = sel_q + PW'(1);
      end
    end
    recall_mode_d = (state_d == ST_RECALL);
    lap_index_d   = recall_mode_d ? 4'(sel_d) + 4'd1 : 4'd0;
    disp_d        = recall_mode_d ? rd_data : live_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LIVE;
      sel_q         <= '0;
      disp_q        <= '0;
      recall_mode_q <= 1'b0;
      lap_index_q   <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      disp_q        <= disp_d;
      recall_mode_q <= recall_mode_d;
      lap_index_q   <= lap_index_d;
    end
  end

  assign disp_ms_ones  = disp_q[MS_ONES_LSB +: 4];
  assign disp_ms_tens  = disp_q[MS_TENS_LSB +: 4];
  assign disp_sec_ones = disp_q[SEC_ONES_LSB +: 4];
  assign disp_sec_tens = disp_q[SEC_TENS_LSB +: 4];
  assign disp_min      = disp_q[MIN_BIT];
  assign recall_mode   = recall_mode_q;
  assign lap_index     = lap_index_q;
  assign lap_count     = cnt;

endmodule

// File: tb/tb_lap_recall_ctrl.sv
// Directed scoreboard bench for lap_recall_ctrl; expectations follow LAP_OVERWRITE_EN.
module tb_lap_recall_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lap_pulse = 1'b0, recall_pulse = 1'b0, clear_pulse = 1'b0, timer_running = 1'b0;
  logic [3:0] live_ms_tens = '0, live_ms_ones = '0, live_sec_tens = '0, live_sec_ones = '0;
  logic live_min = 1'b0;
  logic [3:0] disp_ms_tens, disp_ms_ones, disp_sec_tens, disp_sec_ones;
  logic disp_min, recall_mode, buf_full, lap_reject;
  logic [3:0] lap_index;
  logic [3:0] lap_count;

  lap_recall_ctrl #(.LAP_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .lap_pulse(lap_pulse), .recall_pulse(recall_pulse),
    .clear_pulse(clear_pulse), .timer_running(timer_running),
    .live_ms_tens(live_ms_tens), .live_ms_ones(live_ms_ones),
    .live_sec_tens(live_sec_tens), .live_sec_ones(live_sec_ones), .live_min(live_min),
    .disp_ms_tens(disp_ms_tens), .disp_ms_ones(disp_ms_ones),
    .disp_sec_tens(disp_sec_tens), .disp_sec_ones(disp_sec_ones), .disp_min(disp_min),
    .recall_mode(recall_mode), .lap_index(lap_index), .lap_count(lap_count),
    .buf_full(buf_full), .lap_reject(lap_reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          cyc;
    logic [16:0] disp;
    logic        rm;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic        full;
    logic        rej;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] w(input int m, st, so, mt, mo);
    return {1'(m), 4'(st), 4'(so), 4'(mt), 4'(mo)};
  endfunction

  // Monitor: compares every expectation due at this sample point.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [16:0] ad;
      e  = q.pop_front();
      ad = {disp_min, disp_sec_tens, disp_sec_ones, disp_ms_tens, disp_ms_ones};
      checks++;
      if (e.cyc != cyc || ad !== e.disp || recall_mode !== e.rm || lap_index !== e.idx ||
          lap_count !== e.cnt || buf_full !== e.full || lap_reject !== e.rej) begin
        errors++;
        $display("FAIL %s: got disp=%h rm=%b idx=%0d cnt=%0d full=%b rej=%b, want disp=%h rm=%b idx=%0d cnt=%0d full=%b rej=%b",
                 e.nm, ad, recall_mode, lap_index, lap_count, buf_full, lap_reject,
                 e.disp, e.rm, e.idx, e.cnt, e.full, e.rej);
      end
    end
  end

  task automatic step(input string nm, input bit lp, input bit rc, input bit cl,
                      input logic [16:0] lv, input logic [16:0] ed, input bit erm,
                      input int eidx, input int ecnt, input bit erej);
    exp_t e;
    @(negedge clk);
    lap_pulse = lp; recall_pulse = rc; clear_pulse = cl;
    {live_min, live_sec_tens, live_sec_ones, live_ms_tens, live_ms_ones} = lv;
    e.nm = nm; e.cyc = cyc + 1; e.disp = ed; e.rm = erm;
    e.idx = 4'(eidx); e.cnt = 4'(ecnt); e.full = (ecnt == 8); e.rej = erej;
    q.push_back(e);
  endtask

  initial begin
    logic [16:0] l0, a, b, c, d, g, h, f_i, ew;
    l0 = w(0, 4, 5, 6, 7);
    a  = w(0, 0, 3, 2, 1);
    b  = w(0, 0, 7, 5, 0);
    c  = w(1, 1, 2, 0, 4);
    d  = w(0, 1, 1, 1, 1);
    g  = w(0, 0, 9, 9, 9);
    h  = w(0, 2, 2, 2, 2);

    reset = 1'b1;
    step("reset", 0, 0, 0, l0, '0, 0, 0, 0, 0);
    step("reset_hold", 1, 1, 0, l0, '0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0;
    step("live", 0, 0, 0, l0, l0, 0, 0, 0, 0);

    timer_running = 1'b1;
    step("lap1", 1, 0, 0, a, a, 0, 0, 1, 0);
    step("lap2", 1, 0, 0, b, b, 0, 0, 2, 0);
    step("lap3", 1, 0, 0, c, c, 0, 0, 3, 0);
    step("recall1", 0, 1, 0, l0, a, 1, 1, 3, 0);
    step("recall2", 0, 1, 0, l0, b, 1, 2, 3, 0);
    step("recall3", 0, 1, 0, l0, c, 1, 3, 3, 0);
    step("recall_live", 0, 1, 0, l0, l0, 0, 0, 3, 0);

    timer_running = 1'b0;
    step("lap_stopped", 1, 0, 0, w(0, 5, 5, 5, 5), w(0, 5, 5, 5, 5), 0, 0, 3, 0);
    step("clear", 0, 0, 1, l0, l0, 0, 0, 0, 0);
    step("recall_empty", 0, 1, 0, l0, l0, 0, 0, 0, 0);

    timer_running = 1'b1;
    step("lap_recall_same", 1, 1, 0, d, d, 0, 0, 1, 0);
    step("clear2", 0, 0, 1, l0, l0, 0, 0, 0, 0);

    for (int i = 1; i <= 8; i++) begin
      f_i = w(0, 0, i, 0, 0);
      step($sformatf("fill%0d", i), 1, 0, 0, f_i, f_i, 0, 0, i, 0);
    end
`ifdef LAP_OVERWRITE_EN
    step("lap9", 1, 0, 0, g, g, 0, 0, 8, 0);
`else
    step("lap9", 1, 0, 0, g, g, 0, 0, 8, 1);
`endif
    step("reject_clears", 0, 0, 0, l0, l0, 0, 0, 8, 0);

    for (int i = 1; i <= 8; i++) begin
`ifdef LAP_OVERWRITE_EN
      ew = (i == 8) ? g : w(0, 0, i + 1, 0, 0);
`else
      ew = w(0, 0, i, 0, 0);
`endif
      step($sformatf("full_recall%0d", i), 0, 1, 0, l0, ew, 1, i, 8, 0);
    end
    step("full_recall_live", 0, 1, 0, l0, l0, 0, 0, 8, 0);

`ifdef LAP_OVERWRITE_EN
    step("recall_a1", 0, 1, 0, l0, w(0, 0, 2, 0, 0), 1, 1, 8, 0);
    step("recall_a2", 0, 1, 0, l0, w(0, 0, 3, 0, 0), 1, 2, 8, 0);
`else
    step("recall_a1", 0, 1, 0, l0, w(0, 0, 1, 0, 0), 1, 1, 8, 0);
    step("recall_a2", 0, 1, 0, l0, w(0, 0, 2, 0, 0), 1, 2, 8, 0);
`endif
    step("clear_with_lap", 1, 0, 1, h, h, 0, 0, 0, 0);
    step("no_capture", 0, 0, 0, l0, l0, 0, 0, 0, 0);

    @(negedge clk);
    lap_pulse = 1'b0; recall_pulse = 1'b0; clear_pulse = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
